dpd_adapt_ctrl: RTL and testbench

Sequencer for the DPD adaptation loop. It replaces a free-running window with a controlled schedule: wait for the PA feedback path to settle, open a `dpd_adapt` window of fixed length, then either stop or repeat after a hold gap. During the window it watches the PA-output magnitude from `mag_complex` and aborts on sustained overload. It sits beside `dpd`, drives `dpd.dpd_adapt`, and is controlled by the system/host register layer.

---
 rtl/dpd_adapt_ctrl_pkg.sv | 27 ++
 rtl/dpd_adapt_ctrl_ovl_detect.sv | 40 ++++
 rtl/dpd_adapt_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dpd_adapt_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpd_adapt_ctrl_pkg.sv
// Shared types and default timing for the DPD adaptation sequencer.
package dpd_adapt_ctrl_pkg;

   typedef logic [15:0] u16;
   typedef logic [19:0] u20;
   typedef logic [31:0] u32;

   // Encodings are visible on the debug state port; keep them fixed.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ADAPT  = 2'd2,
      ST_HOLD   = 2'd3
   } dpd_ctrl_state_t;

   // Settle covers the DPD pipeline delay plus the PA feedback delay.
   localparam int DPD_SETTLE_LEN = 1000;
   localparam int DPD_ADAPT_LEN  = 801;
   localparam int DPD_HOLD_LEN   = 4096;
   localparam int DPD_OVL_CNT    = 4;

   // Saturating increment for the completed-window counter.
   function automatic u16 sat_inc16(input u16 v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/dpd_adapt_ctrl_ovl_detect.sv
// Overload detector: strict magnitude compare plus a run-length counter of
// consecutive over-threshold samples. Kept separate so PA protection can reuse it.
module dpd_adapt_ctrl_ovl_detect
   import dpd_adapt_ctrl_pkg::*;
#(
   parameter int OVL_CNT = DPD_OVL_CNT
) (
   input  logic clk,
   input  logic reset_b,
   input  logic arm,
   input  logic clr,
   input  u20   magn,
   input  u20   thr,
   output logic hit
);

   localparam int            OW   = (OVL_CNT > 1) ? $clog2(OVL_CNT) : 1;
   localparam logic [OW-1:0] LAST = OW'(OVL_CNT - 1);

   logic [OW-1:0] run_q;
   logic          over;

   // Equality with the threshold is not an overload.
   assign over = (magn > thr);

   // Fires on the sample that completes the run, so the caller can act on the same edge.
   assign hit = arm & over & (run_q == LAST);

   // Run length of consecutive over-threshold samples; restarts after a hit.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         run_q <= '0;
      end else if (clr || !arm || !over || hit) begin
         run_q <= '0;
      end else begin
         run_q <= run_q + OW'(1);
      end
   end

endmodule

// File: rtl/dpd_adapt_ctrl.sv
// DPD adaptation sequencer: settle, open a fixed adapt window, then stop or
// repeat after a hold gap. Kills the window on sustained PA overload.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for en & start; all outputs low
//   SETTLE | letting the DPD pipeline and PA feedback path settle
//   ADAPT  | dpd_adapt high; overload detector armed
//   HOLD   | gap between iterations in continuous mode
module dpd_adapt_ctrl
   import dpd_adapt_ctrl_pkg::*;
#(
   parameter int SETTLE_LEN = DPD_SETTLE_LEN,
   parameter int ADAPT_LEN  = DPD_ADAPT_LEN,
   parameter int HOLD_LEN   = DPD_HOLD_LEN,
   parameter int OVL_CNT    = DPD_OVL_CNT,
   parameter int CW         = 16
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       en,
   input  logic       start,
   input  logic       cont,
   input  u20         magn_pa,
   input  u20         magn_thr,
   output logic       dpd_adapt,
   output logic       busy,
   output logic       done,
   output logic       abort,
   output u16         iter_cnt,
   output logic [1:0] state
);

   // Counter runs 0..LEN-1 in each timed state; the last value is the terminal count.
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_LEN - 1);
   localparam logic [CW-1:0] ADAPT_LAST  = CW'(ADAPT_LEN - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_LEN - 1);

   dpd_ctrl_state_t state_q, state_nx;
   logic [CW-1:0]   cnt_q, cnt_nx;
   logic [CW-1:0]   cnt_last;
   logic            cnt_tc;
   u16              iter_q, iter_nx;
   logic            done_nx, abort_nx;
   logic            ovl_arm, ovl_clr, ovl_hit;
   logic            dpd_adapt_q, busy_q, done_q, abort_q;

   // Terminal count for whichever timed state is active.
   always_comb begin
      cnt_last = '0;
      case (state_q)
         ST_SETTLE: cnt_last = SETTLE_LAST;
         ST_ADAPT:  cnt_last = ADAPT_LAST;
         ST_HOLD:   cnt_last = HOLD_LAST;
         default:   cnt_last = '0;
      endcase
   end

   assign cnt_tc = (cnt_q == cnt_last);

   // Detector only counts in ADAPT and restarts on every state change, including en drop.
   assign ovl_arm = en & (state_q == ST_ADAPT);
   assign ovl_clr = (state_nx != state_q);

   dpd_adapt_ctrl_ovl_detect #(
      .OVL_CNT (OVL_CNT)
   ) u_ovl_detect (
      .clk     (clk),
      .reset_b (reset_b),
      .arm     (ovl_arm),
      .clr     (ovl_clr),
      .magn    (magn_pa),
      .thr     (magn_thr),
      .hit     (ovl_hit)
   );

   // Next state, cycle counter, completion/abort strobes and window count.
   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      iter_nx  = iter_q;
      done_nx  = 1'b0;
      abort_nx = 1'b0;
      if (!en) begin
         // Silent stop: no done/abort, iteration count kept.
         state_nx = ST_IDLE;
         cnt_nx   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_nx = '0;
               if (start) begin
                  state_nx = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_tc) begin
                  state_nx = ST_ADAPT;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_q + CW'(1);
               end
            end
            ST_ADAPT: begin
               // Overload takes priority over a coincident normal completion.
               if (ovl_hit) begin
                  state_nx = ST_IDLE;
                  cnt_nx   = '0;
                  abort_nx = 1'b1;
               end else if (cnt_tc) begin
                  state_nx = cont ? ST_HOLD : ST_IDLE;
                  cnt_nx   = '0;
                  done_nx  = 1'b1;
                  iter_nx  = sat_inc16(iter_q);
               end else begin
                  cnt_nx = cnt_q + CW'(1);
               end
            end
            ST_HOLD: begin
               // cont is not looked at here; a started hold always runs into SETTLE.
               if (cnt_tc) begin
                  state_nx = ST_SETTLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_q + CW'(1);
               end
            end
            default: begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   // State register and cycle counter.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nx;
         cnt_q   <= cnt_nx;
      end
   end

   // Outputs registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         dpd_adapt_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
         iter_q      <= '0;
      end else begin
         dpd_adapt_q <= (state_nx == ST_ADAPT);
         busy_q      <= (state_nx != ST_IDLE);
         done_q      <= done_nx;
         abort_q     <= abort_nx;
         iter_q      <= iter_nx;
      end
   end

   assign dpd_adapt = dpd_adapt_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign abort     = abort_q;
   assign iter_cnt  = iter_q;
   assign state     = state_q;

endmodule

// File: tb/tb_dpd_adapt_ctrl.sv
// Self-checking bench for dpd_adapt_ctrl. Expected window events (adapt rise,
// done, abort) are queued with their edge number when a start is driven and
// matched as the DUT produces them; state/output spot checks run alongside.
module tb_dpd_adapt_ctrl;

   localparam int SL = 1000;
   localparam int AL = 801;
   localparam int HL = 4096;

   localparam int EV_RISE  = 1;
   localparam int EV_DONE  = 2;
   localparam int EV_ABORT = 3;

   localparam logic [19:0] THR = 20'd300000;

   logic        clk;
   logic        reset_b;
   logic        en;
   logic        start;
   logic        cont;
   logic [19:0] magn_pa;
   logic [19:0] magn_thr;
   logic        dpd_adapt;
   logic        busy;
   logic        done;
   logic        abort;
   logic [15:0] iter_cnt;
   logic [1:0]  state;

   logic        start6;
   logic        cont6;
   logic [19:0] magn6;
   logic        adapt6;
   logic        busy6;
   logic        done6;
   logic        abort6;
   logic [15:0] iter6;
   logic [1:0]  state6;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int kind;
      int at;
      int iter;
   } ev_t;

   ev_t sb[$];

   logic adapt_q = 1'b0;

   int k, d1, r2, d2, r3, d3, exp_iter;

   dpd_adapt_ctrl #(
      .SETTLE_LEN (SL),
      .ADAPT_LEN  (AL),
      .HOLD_LEN   (HL),
      .OVL_CNT    (4),
      .CW         (16)
   ) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .en        (en),
      .start     (start),
      .cont      (cont),
      .magn_pa   (magn_pa),
      .magn_thr  (magn_thr),
      .dpd_adapt (dpd_adapt),
      .busy      (busy),
      .done      (done),
      .abort     (abort),
      .iter_cnt  (iter_cnt),
      .state     (state)
   );

   dpd_adapt_ctrl #(
      .SETTLE_LEN (SL),
      .ADAPT_LEN  (AL),
      .HOLD_LEN   (HL),
      .OVL_CNT    (1),
      .CW         (16)
   ) dut6 (
      .clk       (clk),
      .reset_b   (reset_b),
      .en        (en),
      .start     (start6),
      .cont      (cont6),
      .magn_pa   (magn6),
      .magn_thr  (magn_thr),
      .dpd_adapt (adapt6),
      .busy      (busy6),
      .done      (done6),
      .abort     (abort6),
      .iter_cnt  (iter6),
      .state     (state6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc holds the index of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int at, input int iter);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      e.iter = iter;
      sb.push_back(e);
   endtask

   task automatic take_ev(input int kind);
      ev_t e;
      if (sb.size() == 0) begin
         chk("sb_unexpected_event", kind, 0);
         return;
      end
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_edge", cyc, e.at);
      chk("ev_iter", iter_cnt, e.iter);
   endtask

   // Event monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (dpd_adapt === 1'b1 && adapt_q === 1'b0) take_ev(EV_RISE);
      if (done === 1'b1) begin
         take_ev(EV_DONE);
         chk("done_adapt_low", dpd_adapt, 0);
      end
      if (abort === 1'b1) begin
         take_ev(EV_ABORT);
         chk("abort_adapt_low", dpd_adapt, 0);
      end
      adapt_q = dpd_adapt;
   end

   // Returns on the falling edge after rising edge x; inputs set now are sampled at x+1.
   task automatic after_edge(input int x);
      while (cyc < x) @(negedge clk);
   endtask

   task automatic do_start(input int kk);
      after_edge(kk - 1);
      start = 1'b1;
      after_edge(kk);
      start = 1'b0;
   endtask

   task automatic wait_sb(input int n, input int budget);
      int t = 0;
      while (sb.size() > n && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("sb_wait_timeout", sb.size(), n);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached at edge %0d", cyc);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_b  = 1'b0;
      en       = 1'b0;
      start    = 1'b0;
      cont     = 1'b0;
      magn_pa  = '0;
      magn_thr = THR;
      start6   = 1'b0;
      cont6    = 1'b0;
      magn6    = '0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_state", state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_adapt", dpd_adapt, 0);
      chk("rst_done", done, 0);
      chk("rst_abort", abort, 0);
      chk("rst_iter", iter_cnt, 0);
      reset_b  = 1'b1;
      en       = 1'b1;
      exp_iter = 0;

      // single shot, start sampled at edge 10
      k = 10;
      push_ev(EV_RISE, k + SL, exp_iter);
      push_ev(EV_DONE, k + SL + AL, exp_iter + 1);
      do_start(k);
      chk("s1_busy", busy, 1);
      chk("s1_state_settle", state, 1);
      after_edge(k + 499);
      start = 1'b1;
      after_edge(k + 500);
      start = 1'b0;
      chk("s1_start_busy_ignored", state, 1);
      after_edge(k + SL - 1);
      chk("s1_adapt_before", dpd_adapt, 0);
      after_edge(k + SL + AL - 1);
      chk("s1_adapt_last", dpd_adapt, 1);
      after_edge(k + SL + AL);
      exp_iter = exp_iter + 1;
      chk("s1_done", done, 1);
      chk("s1_iter", iter_cnt, exp_iter);
      chk("s1_idle", state, 0);
      chk("s1_busy_low", busy, 0);
      after_edge(k + SL + AL + 1);
      chk("s1_done_pulse", done, 0);
      wait_sb(0, 10);

      // continuous mode, three windows, cont dropped inside the first hold
      cont = 1'b1;
      k  = cyc + 5;
      d1 = k + SL + AL;
      r2 = d1 + HL + SL;
      d2 = r2 + AL;
      r3 = d2 + HL + SL;
      d3 = r3 + AL;
      push_ev(EV_RISE, k + SL, exp_iter);
      push_ev(EV_DONE, d1, exp_iter + 1);
      push_ev(EV_RISE, r2, exp_iter + 1);
      push_ev(EV_DONE, d2, exp_iter + 2);
      push_ev(EV_RISE, r3, exp_iter + 2);
      push_ev(EV_DONE, d3, exp_iter + 3);
      do_start(k);
      after_edge(d1 + 100);
      chk("s2_hold", state, 3);
      cont = 1'b0;
      after_edge(d1 + HL - 1);
      chk("s2_hold_end", state, 3);
      after_edge(d1 + HL);
      chk("s2_hold_to_settle", state, 1);
      after_edge(r2 + 5);
      cont = 1'b1;
      after_edge(d2 + 10);
      chk("s2_hold2", state, 3);
      after_edge(r3 + 10);
      chk("s2_adapt3", dpd_adapt, 1);
      cont = 1'b0;
      after_edge(d3);
      exp_iter = exp_iter + 3;
      chk("s2_iter", iter_cnt, exp_iter);
      chk("s2_idle", state, 0);
      wait_sb(0, 10);

      // overload: SETTLE samples, 3-burst and equal-magnitude burst are harmless
      k = cyc + 5;
      push_ev(EV_RISE, k + SL, exp_iter);
      push_ev(EV_ABORT, k + SL + 43, exp_iter);
      do_start(k);
      after_edge(k + SL - 6);
      magn_pa = THR + 20'd1;
      after_edge(k + SL);
      magn_pa = '0;
      after_edge(k + SL + 9);
      magn_pa = THR + 20'd1;
      after_edge(k + SL + 12);
      magn_pa = '0;
      after_edge(k + SL + 19);
      magn_pa = THR;
      after_edge(k + SL + 27);
      magn_pa = '0;
      chk("s3_still_adapt", dpd_adapt, 1);
      after_edge(k + SL + 39);
      magn_pa = THR + 20'd1;
      after_edge(k + SL + 42);
      chk("s3_adapt_pre_abort", dpd_adapt, 1);
      after_edge(k + SL + 43);
      magn_pa = '0;
      chk("s3_abort", abort, 1);
      chk("s3_adapt_drop", dpd_adapt, 0);
      chk("s3_idle", state, 0);
      chk("s3_iter", iter_cnt, exp_iter);
      after_edge(k + SL + 44);
      chk("s3_abort_pulse", abort, 0);
      wait_sb(0, 10);

      // disable in SETTLE, start with en low
      k = cyc + 5;
      do_start(k);
      after_edge(k + 100);
      chk("s4_settle", state, 1);
      en = 1'b0;
      after_edge(k + 101);
      chk("s4a_state", state, 0);
      chk("s4a_busy", busy, 0);
      en = 1'b1;
      after_edge(k + 105);
      en    = 1'b0;
      start = 1'b1;
      after_edge(k + 106);
      chk("s4_start_en_low", busy, 0);
      start = 1'b0;
      en    = 1'b1;
      after_edge(k + 110);
      chk("s4_not_queued", busy, 0);

      // disable in ADAPT
      k = cyc + 5;
      push_ev(EV_RISE, k + SL, exp_iter);
      do_start(k);
      after_edge(k + SL + 200);
      chk("s4b_adapt", dpd_adapt, 1);
      en = 1'b0;
      after_edge(k + SL + 201);
      chk("s4b_adapt_low", dpd_adapt, 0);
      chk("s4b_state", state, 0);
      chk("s4b_busy", busy, 0);
      chk("s4b_iter", iter_cnt, exp_iter);
      en = 1'b1;
      wait_sb(0, 5);

      // disable in HOLD
      cont = 1'b1;
      k = cyc + 5;
      push_ev(EV_RISE, k + SL, exp_iter);
      push_ev(EV_DONE, k + SL + AL, exp_iter + 1);
      do_start(k);
      after_edge(k + SL + AL + 50);
      exp_iter = exp_iter + 1;
      chk("s4c_hold", state, 3);
      en   = 1'b0;
      cont = 1'b0;
      after_edge(k + SL + AL + 51);
      chk("s4c_state", state, 0);
      chk("s4c_busy", busy, 0);
      chk("s4c_iter", iter_cnt, exp_iter);
      en = 1'b1;
      after_edge(k + SL + AL + 60);
      wait_sb(0, 5);

      // reset mid-window (start also high during reset), then scenario-1 timing
      k = cyc + 5;
      push_ev(EV_RISE, k + SL, exp_iter);
      do_start(k);
      after_edge(k + SL + 480);
      reset_b = 1'b0;
      start   = 1'b1;
      after_edge(k + SL + 481);
      chk("s5_adapt", dpd_adapt, 0);
      chk("s5_busy", busy, 0);
      chk("s5_done", done, 0);
      chk("s5_abort", abort, 0);
      chk("s5_iter", iter_cnt, 0);
      chk("s5_state", state, 0);
      reset_b  = 1'b1;
      start    = 1'b0;
      exp_iter = 0;
      k = cyc + 10;
      push_ev(EV_RISE, k + SL, exp_iter);
      push_ev(EV_DONE, k + SL + AL, exp_iter + 1);
      do_start(k);
      after_edge(k + SL + AL);
      exp_iter = exp_iter + 1;
      chk("s5_iter_after", iter_cnt, exp_iter);
      chk("s5_idle_after", state, 0);
      wait_sb(0, 10);

      // OVL_CNT=1 instance: overload on the final adapt sample beats completion
      k = cyc + 5;
      after_edge(k - 1);
      start6 = 1'b1;
      after_edge(k);
      start6 = 1'b0;
      chk("s6_busy", busy6, 1);
      after_edge(k + SL + AL - 1);
      chk("s6_adapt_last", adapt6, 1);
      magn6 = THR + 20'd1;
      after_edge(k + SL + AL);
      magn6 = '0;
      chk("s6_abort", abort6, 1);
      chk("s6_no_done", done6, 0);
      chk("s6_adapt_low", adapt6, 0);
      chk("s6_iter", iter6, 0);
      chk("s6_idle", state6, 0);
      after_edge(k + SL + AL + 1);
      chk("s6_no_late_done", done6, 0);
      chk("s6_abort_pulse", abort6, 0);

      wait_sb(0, 10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
